// File: rtl/see_cone_monitor.sv
// Drives an exhaustive stimulus sweep into a golden and a fault-injected cone,
// compares their outputs once per vector and records the mismatch statistics.
module see_cone_monitor #(
  parameter int VEC_W  = 9,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             golden_i,
  input  logic             faulty_i,
  output logic [VEC_W-1:0] vec_o,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_err_vld,
  output logic [VEC_W-1:0] first_err_vec
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE_ST = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  state_t           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fvld_q, fvld_d;
  logic [VEC_W-1:0] fvec_q, fvec_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fvld_q  <= 1'b0;
      fvec_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fvld_q  <= fvld_d;
      fvec_q  <= fvec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fvld_d  = fvld_q;
    fvec_d  = fvec_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          vec_d   = '0;
          err_d   = '0;
          fvld_d  = 1'b0;
          fvec_d  = '0;
          cnt_d   = SETTLE_LD;
          state_d = SETTLE_ST;
        end
      end
      SETTLE_ST: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SAMPLE: begin
        // abort wins: this cycle's comparison is dropped and results hold
        if (abort) begin
          state_d = IDLE;
        end else begin
          if (golden_i != faulty_i) begin
            if (err_q != '1) err_d = err_q + ERR_W'(1);
            if (!fvld_q) begin
              fvld_d = 1'b1;
              fvec_d = vec_q;
            end
          end
          if (vec_q == '1) begin
            state_d = DONE;
          end else begin
            vec_d   = vec_q + VEC_W'(1);
            cnt_d   = SETTLE_LD;
            state_d = SETTLE_ST;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign vec_o         = vec_q;
  assign busy          = (state_q == SETTLE_ST) || (state_q == SAMPLE);
  assign done          = (state_q == DONE);
  assign err_cnt       = err_q;
  assign first_err_vld = fvld_q;
  assign first_err_vec = fvec_q;

endmodule

// File: tb/tb_see_cone_monitor.sv
// Directed bench for see_cone_monitor (VEC_W=3, SETTLE=2); a second instance
// with ERR_W=2 sees a permanently inverted faulty output to exercise saturation.
module tb_see_cone_monitor;

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic       golden, faulty, golden2, faulty2;
  logic [2:0] vec, fvec, vec2, fvec2;
  logic       busy, done, fvld, busy2, done2, fvld2;
  logic [15:0] err;
  logic [1:0]  err2;
  int         mode;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  see_cone_monitor #(.VEC_W(3), .SETTLE(2), .ERR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .golden_i(golden), .faulty_i(faulty), .vec_o(vec), .busy(busy),
    .done(done), .err_cnt(err), .first_err_vld(fvld), .first_err_vec(fvec)
  );

  see_cone_monitor #(.VEC_W(3), .SETTLE(2), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .golden_i(golden2), .faulty_i(faulty2), .vec_o(vec2), .busy(busy2),
    .done(done2), .err_cnt(err2), .first_err_vld(fvld2), .first_err_vec(fvec2)
  );

  // golden cone stand-in is parity; mode selects which vectors get flipped
  always_comb begin
    golden  = ^vec;
    golden2 = ^vec2;
    faulty2 = ~golden2;
    faulty  = golden;
    case (mode)
      1: faulty = golden ^ (vec == 3'd5);
      2: faulty = golden ^ (vec == 3'd4);
      3: faulty = golden ^ ((vec == 3'd2) || (vec == 3'd6));
      default: faulty = golden;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, then follow the campaign; dcyc = cycle (start edge -> cycle 1)
  // in which done is seen, bad = cycles where vec/busy deviate from the sweep.
  task automatic run(output int dcyc, output int bad);
    int cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc  = 1;
    bad  = 0;
    dcyc = -1;
    while (cyc <= 60) begin
      if (done) begin
        dcyc = cyc;
        break;
      end
      if (int'(vec) != (cyc - 1) / 3 || busy !== 1'b1) bad++;
      tick();
      cyc++;
    end
  endtask

  int dcyc, bad, cyc, seen;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 0;
    tick(); tick();
    chk("rst_vec", 32'(vec), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_fvld", 32'(fvld), 0);
    chk("rst_fvec", 32'(fvec), 0);
    rst_n = 1'b1;
    tick();

    // clean sweep: 3 cycles per vector, done in cycle 25
    run(dcyc, bad);
    chk("clean_done_cyc", 32'(dcyc), 25);
    chk("clean_steps", 32'(bad), 0);
    chk("clean_err", 32'(err), 0);
    chk("clean_fvld", 32'(fvld), 0);
    chk("clean_vec_hold", 32'(vec), 7);
    chk("sat_err", 32'(err2), 3);
    chk("sat_fvec", 32'(fvec2), 0);
    chk("sat_fvld", 32'(fvld2), 1);
    tick();

    // single mismatch at vector 5
    mode = 1;
    run(dcyc, bad);
    chk("m5_done_cyc", 32'(dcyc), 25);
    chk("m5_err", 32'(err), 1);
    chk("m5_fvld", 32'(fvld), 1);
    chk("m5_fvec", 32'(fvec), 5);
    abort = 1'b1;
    tick(); tick();
    abort = 1'b0;
    chk("idle_abort_err", 32'(err), 1);
    chk("idle_abort_fvec", 32'(fvec), 5);
    chk("idle_busy", 32'(busy), 0);

    // two mismatches: only the first is captured
    mode = 3;
    run(dcyc, bad);
    chk("m26_err", 32'(err), 2);
    chk("m26_fvec", 32'(fvec), 2);
    chk("m26_fvld", 32'(fvld), 1);
    tick();

    // abort during SAMPLE of vector 4 (cycle 15) while it mismatches
    mode = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 2; i <= 15; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", 32'(busy), 0);
    chk("ab_done", 32'(done), 0);
    chk("ab_err", 32'(err), 0);
    chk("ab_fvld", 32'(fvld), 0);
    chk("ab_vec", 32'(vec), 4);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) seen++;
      tick();
    end
    chk("ab_no_done", 32'(seen), 0);

    // start held high: back-to-back campaigns restart from IDLE only
    mode = 1;
    start = 1'b1;
    tick();
    cyc = 1;
    while (!done && cyc < 60) begin tick(); cyc++; end
    chk("bb_done1_cyc", 32'(cyc), 25);
    tick(); cyc++;
    chk("bb_idle_busy", 32'(busy), 0);
    chk("bb_idle_err", 32'(err), 1);
    tick(); cyc++;
    chk("bb_restart_busy", 32'(busy), 1);
    chk("bb_restart_err", 32'(err), 0);
    chk("bb_restart_vec", 32'(vec), 0);
    while (!done && cyc < 100) begin tick(); cyc++; end
    chk("bb_done2_cyc", 32'(cyc), 51);
    start = 1'b0;
    tick(); tick();
    chk("bb_stop_busy", 32'(busy), 0);

    // reset mid-campaign at vector 6
    mode = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (vec != 3'd6 && cyc < 40) begin tick(); cyc++; end
    chk("rs_reach6", 32'(vec), 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_vec", 32'(vec), 0);
    chk("rs_busy", 32'(busy), 0);
    chk("rs_done", 32'(done), 0);
    chk("rs_err", 32'(err), 0);
    chk("rs_fvld", 32'(fvld), 0);
    chk("rs_fvec", 32'(fvec), 0);
    tick(); tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (done || busy) seen++;
      tick();
    end
    chk("rs_quiet", 32'(seen), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rs_first_start", 32'(busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("rs_settle_abort", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/see_cone_monitor.md
SEE_CONE_MONITOR -- requirements
Module: see_cone_monitor

Interface
REQ-001 Parameter VEC_W, default 9: width of the stimulus vector applied to the cone inputs i_0_..i_8_ (bit n drives i_n_).
REQ-002 Parameter SETTLE, default 2: cycles allowed for cone propagation per vector; legal range is 1..15.
REQ-003 Parameter ERR_W, default 16: width of the mismatch counter.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port start, input, 1: level-sampled campaign request; honoured only in IDLE.
REQ-007 Port abort, input, 1: terminates a running campaign.
REQ-008 Port golden_i, input, 1: output of the fault-free cone instance.
REQ-009 Port faulty_i, input, 1: output of the fault-injected cone instance.
REQ-010 Port vec_o, output, VEC_W: registered stimulus driven to both cone instances.
REQ-011 Port busy, output, 1: high in SETTLE and SAMPLE.
REQ-012 Port done, output, 1: one-cycle pulse when a campaign completes.
REQ-013 Port err_cnt, output, ERR_W: count of mismatching vectors.
REQ-014 Port first_err_vld, output, 1: high once any mismatch has been captured in the current campaign.
REQ-015 Port first_err_vec, output, VEC_W: vector at which the first mismatch occurred.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, SETTLE, SAMPLE and DONE.
REQ-017 IDLE with start=1: on the next edge, vec_o is set to 0; err_cnt, first_err_vld and first_err_vec are set to 0; the settle counter is loaded with SETTLE-1; the state goes to SETTLE.
REQ-018 SETTLE: the settle counter decrements each cycle; when it reaches 0, the state goes to SAMPLE on the next edge.
REQ-019 SAMPLE lasts one cycle; a mismatch (golden_i != faulty_i) is registered at the edge that leaves SAMPLE.
REQ-020 When a mismatch is registered, err_cnt increments, saturating at 2^ERR_W-1 with no wrap.
REQ-021 On the first mismatch only, first_err_vec takes the current vec_o and first_err_vld is set to 1.
REQ-022 Leaving SAMPLE with vec_o != all-ones: vec_o increments, the settle counter reloads, and the state goes to SETTLE.
REQ-023 Leaving SAMPLE with vec_o == all-ones: vec_o holds, with no wrap, and the state goes to DONE.
REQ-024 Each vector SHALL occupy exactly SETTLE+1 cycles; vec_o SHALL be stable for that entire window.
REQ-025 DONE lasts one cycle with done=1 and busy=0, then returns to IDLE.
REQ-026 start SHALL be ignored in SETTLE, SAMPLE and DONE.
REQ-027 abort=1 in SETTLE or SAMPLE: the next state is IDLE, no done pulse is issued, and the comparison of that cycle is discarded.
REQ-028 abort SHALL take priority over the SAMPLE capture when both occur in the same cycle.
REQ-029 On abort, err_cnt, first_err_* and vec_o SHALL hold their values.
REQ-030 abort SHALL have no effect in IDLE or DONE.
REQ-031 Results (err_cnt, first_err_*) SHALL hold in IDLE until the next accepted start.

Reset
REQ-032 While rst_n=0: state=IDLE, vec_o=0, busy=0, done=0, err_cnt=0, first_err_vld=0, first_err_vec=0, settle counter=0.
REQ-033 Reset asserted mid-campaign SHALL abandon the campaign immediately, with no done pulse.
REQ-034 After reset deasserts, the first accepted start SHALL be honoured on the next edge.

Verification (VEC_W=3, SETTLE=2, ERR_W=16 unless stated)
REQ-035 Scenario: faulty_i tied to golden_i, start pulsed -> vec_o steps 0..7 with 3 cycles per value; done pulses 25 cycles after the start edge; err_cnt=0; first_err_vld=0.
REQ-036 Scenario: faulty_i = golden_i XOR (vec_o==5) -> err_cnt=1, first_err_vld=1, first_err_vec=5.
REQ-037 Scenario: ERR_W=2, faulty_i = ~golden_i throughout -> err_cnt=3 (saturated), first_err_vec=0.
REQ-038 Scenario: abort asserted during the SAMPLE cycle for vec_o=4, with a mismatch at vec 4 only -> err_cnt=0, vec_o holds 4, IDLE next cycle, no done pulse.
REQ-039 Scenario: start held high continuously -> campaigns repeat back-to-back; each restarts only from IDLE, one cycle after done; counters clear at each restart.
REQ-040 Scenario: rst_n pulsed low while vec_o=6 -> all outputs are 0 immediately; no done pulse follows.
